// File: rtl/gba_io_mem_pkg.sv
// rtl/gba_io_mem_pkg.sv - shared types and constants for the GBA I/O memory arbiter
// Contents: access width codes, arbiter state encoding, port owner encoding.
package gba_io_mem_pkg;

  localparam logic [1:0] DATA_WIDTH_0  = 2'b00;
  localparam logic [1:0] DATA_WIDTH_8  = 2'b01;
  localparam logic [1:0] DATA_WIDTH_16 = 2'b10;
  localparam logic [1:0] DATA_WIDTH_32 = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_RD = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CART = 2'd1,
    USB  = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the memory-controller port between the cart and USB engines
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   cart_req/we/addr/width/wdata          cart command (held until cart_done)
//   cart_rdata, cart_done                 cart read data and completion pulse
//   usb_req/we/addr/wdata                 USB command (always 32-bit)
//   usb_rdata, usb_done                   USB read data and completion pulse
//   mem_rd, mem_wr                        one-cycle command pulses to the controller
//   mem_addr, mem_width, mem_wdata        latched command fields
//   mem_rd_ready, mem_wr_ready            controller can accept a read / write
//   mem_rd_valid, mem_rd_data             read response
//   owner                                 current owner (0 none, 1 cart, 2 usb)
//   timeout_err                           sticky read-timeout flag
module mem_arbiter
  import gba_io_mem_pkg::*;
#(
  parameter int MAX_CART_STREAK = 4,
  parameter int RD_TIMEOUT      = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cart_req,
  input  logic        cart_we,
  input  logic [25:0] cart_addr,
  input  logic [1:0]  cart_width,
  input  logic [15:0] cart_wdata,
  output logic [15:0] cart_rdata,
  output logic        cart_done,
  input  logic        usb_req,
  input  logic        usb_we,
  input  logic [25:0] usb_addr,
  input  logic [31:0] usb_wdata,
  output logic [31:0] usb_rdata,
  output logic        usb_done,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [25:0] mem_addr,
  output logic [1:0]  mem_width,
  output logic [31:0] mem_wdata,
  input  logic        mem_rd_ready,
  input  logic        mem_wr_ready,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  output logic [1:0]  owner,
  output logic        timeout_err
);

  localparam int SW = $clog2(MAX_CART_STREAK + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CART_STREAK);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(RD_TIMEOUT - 1);

  arb_state_t  state_q, state_d;
  owner_t      owner_q, owner_d;
  logic        issued_q, issued_d;
  logic        we_q, we_d;
  logic [25:0] addr_q, addr_d;
  logic [1:0]  width_q, width_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] cart_rdata_q, cart_rdata_d;
  logic [31:0] usb_rdata_q, usb_rdata_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic        terr_q, terr_d;

  logic        cart_wins;
  logic [31:0] rd_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= NONE;
      issued_q     <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      width_q      <= '0;
      wdata_q      <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      cart_rdata_q <= '0;
      usb_rdata_q  <= '0;
      streak_q     <= '0;
      tcnt_q       <= '0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      issued_q     <= issued_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      width_q      <= width_d;
      wdata_q      <= wdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      cart_rdata_q <= cart_rdata_d;
      usb_rdata_q  <= usb_rdata_d;
      streak_q     <= streak_d;
      tcnt_q       <= tcnt_d;
      terr_q       <= terr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    issued_d     = issued_q;
    we_d         = we_q;
    addr_d       = addr_q;
    width_d      = width_q;
    wdata_d      = wdata_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    cart_rdata_d = cart_rdata_q;
    usb_rdata_d  = usb_rdata_q;
    streak_d     = streak_q;
    tcnt_d       = tcnt_q;
    terr_d       = terr_q;
    rd_word      = '0;
    // Cart has latency priority until it has starved a waiting USB request long enough.
    cart_wins    = cart_req && !(usb_req && (streak_q == STREAK_MAX));

    case (state_q)
      IDLE: begin
        if (!usb_req) streak_d = '0;
        issued_d = 1'b0;
        if (cart_wins) begin
          state_d = ISSUE;
          owner_d = CART;
          we_d    = cart_we;
          addr_d  = cart_addr;
          width_d = cart_width;
          wdata_d = {16'h0000, cart_wdata};
          if (usb_req) streak_d = streak_q + SW'(1);
        end else if (usb_req) begin
          state_d  = ISSUE;
          owner_d  = USB;
          we_d     = usb_we;
          addr_d   = usb_addr;
          width_d  = DATA_WIDTH_32;
          wdata_d  = usb_wdata;
          streak_d = '0;
        end
      end
      ISSUE: begin
        // First ISSUE cycle waits for ready and registers the pulse; the second
        // cycle is the pulse itself, after which the command has been handed off.
        if (!issued_q) begin
          if (we_q ? mem_wr_ready : mem_rd_ready) begin
            issued_d = 1'b1;
            mem_wr_d = we_q;
            mem_rd_d = !we_q;
          end
        end else begin
          issued_d = 1'b0;
          tcnt_d   = '0;
          state_d  = we_q ? DONE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (mem_rd_valid) begin
          rd_word = mem_rd_data;
          state_d = DONE;
        end else if (tcnt_q == TCNT_LAST) begin
          terr_d  = 1'b1;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
        if (state_d == DONE) begin
          if (owner_q == CART) cart_rdata_d = rd_word[15:0];
          else                 usb_rdata_d  = rd_word;
        end
      end
      DONE: state_d = RELEASE;
      RELEASE: begin
        state_d = IDLE;
        owner_d = NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = NONE;
      end
    endcase
  end

  assign cart_rdata  = cart_rdata_q;
  assign usb_rdata   = usb_rdata_q;
  assign cart_done   = (state_q == DONE) && (owner_q == CART);
  assign usb_done    = (state_q == DONE) && (owner_q == USB);
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = addr_q;
  assign mem_width   = width_q;
  assign mem_wdata   = wdata_q;
  assign owner       = owner_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cart_req, cart_we, cart_done;
  logic [25:0] cart_addr;
  logic [1:0]  cart_width;
  logic [15:0] cart_wdata, cart_rdata;
  logic        usb_req, usb_we, usb_done;
  logic [25:0] usb_addr;
  logic [31:0] usb_wdata, usb_rdata;
  logic        mem_rd, mem_wr, mem_rd_ready, mem_wr_ready, mem_rd_valid;
  logic [25:0] mem_addr;
  logic [1:0]  mem_width;
  logic [31:0] mem_wdata, mem_rd_data;
  logic [1:0]  owner;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  int rd_cyc, wr_cyc, done_cyc, nrd, nwr, nother;
  logic [25:0] addr_seen;
  logic [1:0]  width_seen;
  logic [31:0] wdata_seen;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_CART_STREAK(4), .RD_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .cart_req(cart_req), .cart_we(cart_we), .cart_addr(cart_addr),
    .cart_width(cart_width), .cart_wdata(cart_wdata),
    .cart_rdata(cart_rdata), .cart_done(cart_done),
    .usb_req(usb_req), .usb_we(usb_we), .usb_addr(usb_addr),
    .usb_wdata(usb_wdata), .usb_rdata(usb_rdata), .usb_done(usb_done),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_width(mem_width), .mem_wdata(mem_wdata),
    .mem_rd_ready(mem_rd_ready), .mem_wr_ready(mem_wr_ready),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .owner(owner), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One transaction. Cycle 0 is the cycle whose inputs first carry req.
  // vlat < 0 means the read response never arrives.
  task automatic run_txn(input bit usb, input bit we, input logic [25:0] a,
                         input logic [31:0] wd, input logic [1:0] w,
                         input int rdy_lo, input int vlat, input logic [31:0] rd);
    int n;
    n = 0; rd_cyc = -1; wr_cyc = -1; done_cyc = -1; nrd = 0; nwr = 0; nother = 0;
    while (done_cyc < 0 && n < 60) begin
      @(negedge clk);
      if (mem_rd) begin nrd++; rd_cyc = n; addr_seen = mem_addr; width_seen = mem_width; end
      if (mem_wr) begin nwr++; wr_cyc = n; addr_seen = mem_addr; width_seen = mem_width; wdata_seen = mem_wdata; end
      if (usb ? usb_done : cart_done) done_cyc = n;
      if (usb ? cart_done : usb_done) nother++;
      if (n == 0) begin
        if (usb) begin
          usb_req = 1'b1; usb_we = we; usb_addr = a; usb_wdata = wd;
        end else begin
          cart_req = 1'b1; cart_we = we; cart_addr = a; cart_wdata = wd[15:0]; cart_width = w;
        end
      end
      mem_rd_ready = (n >= rdy_lo);
      mem_wr_ready = (n >= rdy_lo);
      mem_rd_valid = (vlat >= 0) && (rd_cyc >= 0) && (n == rd_cyc + vlat);
      mem_rd_data  = mem_rd_valid ? rd : 32'h5A5A5A5A;
      if (done_cyc >= 0) begin
        cart_req = 1'b0; usb_req = 1'b0;
      end
      n++;
    end
    mem_rd_valid = 1'b0;
    check("txn_done_seen", 32'(done_cyc >= 0), 32'd1);
    check("txn_no_other_done", 32'(nother), 32'd0);
  endtask

  initial begin
    int n, k;
    int seq[10];
    int viol, wrs;
    int expseq[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

    rst = 1'b1;
    cart_req = 0; cart_we = 0; cart_addr = '0; cart_width = '0; cart_wdata = '0;
    usb_req = 0; usb_we = 0; usb_addr = '0; usb_wdata = '0;
    mem_rd_ready = 0; mem_wr_ready = 0; mem_rd_valid = 0; mem_rd_data = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_pulses", {29'd0, mem_rd, mem_wr, cart_done | usb_done}, 32'd0);
    check("rst_fields", {4'd0, mem_addr, mem_width}, 32'd0);
    check("rst_rdata_terr", {cart_rdata, 15'd0, timeout_err}, 32'd0);

    // Cart read, response 3 cycles after mem_rd
    run_txn(1'b0, 1'b0, 26'h0000100, 32'h0, 2'b10, 0, 3, 32'hDEADBEEF);
    check("crd_nrd", 32'(nrd), 32'd1);
    check("crd_nwr", 32'(nwr), 32'd0);
    check("crd_rd_cyc", 32'(rd_cyc), 32'd2);
    check("crd_done_cyc", 32'(done_cyc), 32'd6);
    check("crd_addr", 32'(addr_seen), 32'h0000100);
    check("crd_width", 32'(width_seen), 32'd2);
    check("crd_rdata", 32'(cart_rdata), 32'h0000BEEF);
    check("crd_usb_rdata", usb_rdata, 32'h0);
    tick(2);
    check("crd_owner_idle", 32'(owner), 32'd0);

    // USB write with controller not ready for 5 cycles
    run_txn(1'b1, 1'b1, 26'h2000000, 32'h12345678, 2'b00, 5, -1, 32'h0);
    check("uwr_nwr", 32'(nwr), 32'd1);
    check("uwr_nrd", 32'(nrd), 32'd0);
    check("uwr_wr_cyc", 32'(wr_cyc), 32'd6);
    check("uwr_done_cyc", 32'(done_cyc), 32'd7);
    check("uwr_wdata", wdata_seen, 32'h12345678);
    check("uwr_width", 32'(width_seen), 32'd3);
    check("uwr_addr", 32'(addr_seen), 32'h2000000);
    tick(2);

    // Both requesters held high: streak forces USB every fifth grant
    cart_req = 1; usb_req = 1; cart_we = 1; usb_we = 1;
    mem_rd_ready = 1; mem_wr_ready = 1;
    k = 0; viol = 0; wrs = 0; n = 0;
    while (k < 10 && n < 100) begin
      @(negedge clk);
      if (cart_done && usb_done) viol++;
      if (mem_rd && mem_wr) viol++;
      if (mem_wr) wrs++;
      if (mem_rd) viol++;
      if (cart_done) begin seq[k] = 1; k++; end
      else if (usb_done) begin seq[k] = 2; k++; end
      n++;
    end
    cart_req = 0; usb_req = 0;
    check("streak_count", 32'(k), 32'd10);
    check("streak_viol", 32'(viol), 32'd0);
    check("streak_writes", 32'(wrs), 32'd10);
    for (int i = 0; i < 10; i++) check($sformatf("streak_grant%0d", i), 32'(seq[i]), 32'(expseq[i]));
    tick(2);

    // Cart read whose response never returns
    run_txn(1'b0, 1'b0, 26'h0000200, 32'h0, 2'b01, 0, -1, 32'h0);
    check("tmo_rd_cyc", 32'(rd_cyc), 32'd2);
    check("tmo_done_cyc", 32'(done_cyc), 32'd18);
    check("tmo_rdata", 32'(cart_rdata), 32'h0);
    check("tmo_err", 32'(timeout_err), 32'd1);
    tick(2);
    run_txn(1'b0, 1'b1, 26'h0000300, 32'h0000ABCD, 2'b10, 0, -1, 32'h0);
    check("tmo_err_sticky", 32'(timeout_err), 32'd1);
    tick(2);

    // Reset in WAIT_RD, late response arrives 2 cycles after reset is raised
    @(negedge clk);
    usb_req = 1; usb_we = 0; usb_addr = 26'h0000040; mem_rd_ready = 1;
    n = 0;
    while (!mem_rd && n < 20) begin @(negedge clk); n++; end
    check("rstw_rd_seen", 32'(mem_rd), 32'd1);
    @(negedge clk);
    rst = 1; usb_req = 0;
    @(negedge clk);
    rst = 0;
    check("rstw_owner", 32'(owner), 32'd0);
    check("rstw_terr", 32'(timeout_err), 32'd0);
    check("rstw_outs", {mem_rd, mem_wr, cart_done, usb_done, 2'b00, mem_addr}, 32'd0);
    @(negedge clk);
    mem_rd_valid = 1; mem_rd_data = 32'h11112222;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_rd_valid = 0;
      if (usb_done || cart_done || owner != 2'd0) k++;
    end
    check("rstw_no_done", 32'(k), 32'd0);
    check("rstw_usb_rdata", usb_rdata, 32'h0);

    run_txn(1'b1, 1'b0, 26'h0000080, 32'h0, 2'b00, 0, 2, 32'hCAFEF00D);
    check("post_rd_cyc", 32'(rd_cyc), 32'd2);
    check("post_done_cyc", 32'(done_cyc), 32'd5);
    check("post_usb_rdata", usb_rdata, 32'hCAFEF00D);
    check("post_width", 32'(width_seen), 32'd3);
    check("post_cart_rdata", 32'(cart_rdata), 32'h0);
    tick(2);
    check("post_owner_idle", 32'(owner), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
